// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - PC register, redirect, instruction memory and decode signals of the fetch unit
interface fetch_unit_if #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]  i_pc;
  logic                   o_pc_write_en;
  logic [ADDR_WIDTH-1:0]  o_pc_next;
  logic                   i_redirect_valid;
  logic [ADDR_WIDTH-1:0]  i_redirect_pc;
  logic                   o_mem_req_valid;
  logic                   i_mem_req_ready;
  logic [ADDR_WIDTH-1:0]  o_mem_addr;
  logic                   i_mem_resp_valid;
  logic [INSTR_WIDTH-1:0] i_mem_resp_data;
  logic                   i_mem_resp_err;
  logic                   o_instr_valid;
  logic                   i_instr_ready;
  logic [INSTR_WIDTH-1:0] o_instr;
  logic [ADDR_WIDTH-1:0]  o_instr_pc;
  logic                   o_instr_fault;

  // master is the fetch unit itself; slave is the PC register, memory and decode side
  modport master (
    input  i_pc, i_redirect_valid, i_redirect_pc, i_mem_req_ready,
           i_mem_resp_valid, i_mem_resp_data, i_mem_resp_err, i_instr_ready,
    output o_pc_write_en, o_pc_next, o_mem_req_valid, o_mem_addr,
           o_instr_valid, o_instr, o_instr_pc, o_instr_fault
  );

  modport slave (
    output i_pc, i_redirect_valid, i_redirect_pc, i_mem_req_ready,
           i_mem_resp_valid, i_mem_resp_data, i_mem_resp_err, i_instr_ready,
    input  o_pc_write_en, o_pc_next, o_mem_req_valid, o_mem_addr,
           o_instr_valid, o_instr, o_instr_pc, o_instr_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding in-order instruction fetch with redirect and holding register
module fetch_unit #(
  parameter int ADDR_WIDTH  = 64,
  parameter int INSTR_WIDTH = 32,
  parameter int PC_STEP     = 4
) (
  input  logic          clk,
  input  logic          arstn,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_fetch_pc;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_instr_pc;
  logic                   r_instr_fault;

  logic                   w_redirect;
  logic                   w_req_valid;
  logic                   w_accept;
  logic                   w_load;
  logic                   w_instr_valid;
  logic                   w_consume;

  assign w_redirect = bus.i_redirect_valid;

  always_comb begin
    w_state_nxt   = r_state;
    w_req_valid   = 1'b0;
    w_accept      = 1'b0;
    w_load        = 1'b0;
    w_instr_valid = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req_valid = ~w_redirect;
        if (w_req_valid && bus.i_mem_req_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect kills the fetch; without its response we must still absorb it later
        if (w_redirect) begin
          w_state_nxt = bus.i_mem_resp_valid ? S_REQ : S_DRAIN;
        end else if (bus.i_mem_resp_valid) begin
          w_load      = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        w_instr_valid = ~w_redirect;
        if (w_redirect || bus.i_instr_ready) begin
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        // The stale response always ends the drain, even alongside another redirect
        if (bus.i_mem_resp_valid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign w_consume = w_instr_valid & bus.i_instr_ready;

  // Outputs are forced low while reset is asserted, including the combinational ones
  assign bus.o_mem_req_valid = arstn & w_req_valid;
  assign bus.o_mem_addr      = (arstn && (r_state == S_REQ)) ? bus.i_pc : r_fetch_pc;
  assign bus.o_instr_valid   = arstn & w_instr_valid;
  assign bus.o_pc_write_en   = arstn & (w_redirect | w_consume);
  assign bus.o_pc_next       = !arstn     ? '0 :
                               w_redirect ? bus.i_redirect_pc :
                               w_consume  ? r_instr_pc + ADDR_WIDTH'(PC_STEP) : '0;
  assign bus.o_instr         = r_instr;
  assign bus.o_instr_pc      = r_instr_pc;
  assign bus.o_instr_fault   = r_instr_fault;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_fault <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_fetch_pc <= bus.i_pc;
      end
      if (w_load) begin
        r_instr       <= bus.i_mem_resp_err ? '0 : bus.i_mem_resp_data;
        r_instr_pc    <= r_fetch_pc;
        r_instr_fault <= bus.i_mem_resp_err;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_3000_0000;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic arstn = 1'b1;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];

  fetch_unit_if #(.ADDR_WIDTH(64), .INSTR_WIDTH(32)) bus ();

  fetch_unit #(.ADDR_WIDTH(64), .INSTR_WIDTH(32), .PC_STEP(4)) dut (
    .clk   (clk),
    .arstn (arstn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // PC register the fetch unit reads and writes
  always @(posedge clk or negedge arstn) begin
    if (!arstn) bus.i_pc <= RESET_PC;
    else if (bus.o_pc_write_en) bus.i_pc <= bus.o_pc_next;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_mem_req_ready  = 1'b0;
    bus.i_mem_resp_valid = 1'b0;
    bus.i_mem_resp_data  = '0;
    bus.i_mem_resp_err   = 1'b0;
    bus.i_instr_ready    = 1'b0;
  endtask

  task automatic issue_req(output logic [63:0] addr);
    int n = 0;
    @(negedge clk);
    bus.i_mem_req_ready = 1'b1;
    #1;
    while (bus.o_mem_req_valid !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) $display("FAIL issue_req_timeout: got no request, expected request within 20 cycles");
    else passed++;
    addr = bus.o_mem_addr;
    @(negedge clk);
    bus.i_mem_req_ready = 1'b0;
  endtask

  task automatic give_resp(input int lat, input logic [31:0] data, input logic err, input logic [63:0] addr);
    exp_t e;
    repeat (lat - 1) @(negedge clk);
    bus.i_mem_resp_valid = 1'b1;
    bus.i_mem_resp_data  = data;
    bus.i_mem_resp_err   = err;
    e.instr = err ? 32'h0 : data;
    e.pc    = addr;
    e.fault = err;
    sb.push_back(e);
    @(negedge clk);
    bus.i_mem_resp_valid = 1'b0;
    bus.i_mem_resp_err   = 1'b0;
    #1;
  endtask

  task automatic consume();
    exp_t e = '{instr: 32'h0, pc: 64'h0, fault: 1'b0};
    int n = 0;
    while (bus.o_instr_valid !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (n >= 20) $display("FAIL consume_timeout: got no o_instr_valid, expected within 20 cycles");
    else passed++;
    checks++;
    if (sb.size() == 0) $display("FAIL sb_empty: got instruction, expected none");
    else begin passed++; e = sb.pop_front(); end
    checks++;
    if (bus.o_instr !== e.instr) $display("FAIL instr: got %h expected %h", bus.o_instr, e.instr);
    else passed++;
    checks++;
    if (bus.o_instr_pc !== e.pc) $display("FAIL instr_pc: got %h expected %h", bus.o_instr_pc, e.pc);
    else passed++;
    checks++;
    if (bus.o_instr_fault !== e.fault) $display("FAIL instr_fault: got %b expected %b", bus.o_instr_fault, e.fault);
    else passed++;
    bus.i_instr_ready = 1'b1;
    #1;
    checks++;
    if (bus.o_pc_write_en !== 1'b1) $display("FAIL consume_pc_we: got %b expected 1", bus.o_pc_write_en);
    else passed++;
    checks++;
    if (bus.o_pc_next !== e.pc + 64'd4) $display("FAIL consume_pc_next: got %h expected %h", bus.o_pc_next, e.pc + 64'd4);
    else passed++;
    @(negedge clk);
    bus.i_instr_ready = 1'b0;
    #1;
    checks++;
    if (bus.o_pc_write_en !== 1'b0) $display("FAIL after_consume_pc_we: got %b expected 0", bus.o_pc_write_en);
    else passed++;
    checks++;
    if (bus.o_mem_req_valid !== 1'b1 || bus.o_mem_addr !== e.pc + 64'd4)
      $display("FAIL next_req: got valid=%b addr=%h expected valid=1 addr=%h", bus.o_mem_req_valid, bus.o_mem_addr, e.pc + 64'd4);
    else passed++;
  endtask

  task automatic test_reset();
    drive_idle();
    #1 arstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.o_mem_req_valid, bus.o_pc_write_en, bus.o_instr_valid, bus.o_instr_fault} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {bus.o_mem_req_valid, bus.o_pc_write_en, bus.o_instr_valid, bus.o_instr_fault});
    else passed++;
    checks++;
    if (bus.o_mem_addr !== 64'h0 || bus.o_pc_next !== 64'h0)
      $display("FAIL reset_addr: got addr=%h next=%h expected 0", bus.o_mem_addr, bus.o_pc_next);
    else passed++;
    checks++;
    if (bus.o_instr !== 32'h0 || bus.o_instr_pc !== 64'h0)
      $display("FAIL reset_instr: got instr=%h pc=%h expected 0", bus.o_instr, bus.o_instr_pc);
    else passed++;
    @(negedge clk);
    arstn = 1'b1;
    #1;
    checks++;
    if (bus.o_mem_req_valid !== 1'b1 || bus.o_mem_addr !== RESET_PC)
      $display("FAIL release_req: got valid=%b addr=%h expected valid=1 addr=%h", bus.o_mem_req_valid, bus.o_mem_addr, RESET_PC);
    else passed++;
  endtask

  task automatic test_fetch();
    logic [63:0] addr;
    issue_req(addr);
    checks++;
    if (addr !== RESET_PC) $display("FAIL fetch_addr: got %h expected %h", addr, RESET_PC);
    else passed++;
    give_resp(2, 32'h0000_0013, 1'b0, addr);
    consume();
  endtask

  task automatic test_backpressure();
    logic [63:0] addr;
    issue_req(addr);
    give_resp(1, 32'hDEAD_BEEF, 1'b0, addr);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.o_instr_valid !== 1'b1 || bus.o_instr !== 32'hDEAD_BEEF || bus.o_instr_pc !== addr)
        $display("FAIL bp_hold[%0d]: got valid=%b instr=%h pc=%h expected 1 deadbeef %h", i, bus.o_instr_valid, bus.o_instr, bus.o_instr_pc, addr);
      else passed++;
      checks++;
      if (bus.o_mem_req_valid !== 1'b0 || bus.o_pc_write_en !== 1'b0)
        $display("FAIL bp_quiet[%0d]: got req=%b we=%b expected 0 0", i, bus.o_mem_req_valid, bus.o_pc_write_en);
      else passed++;
      @(negedge clk); #1;
    end
    consume();
  endtask

  task automatic test_redirect_wait();
    logic [63:0] addr;
    issue_req(addr);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 64'h3000_0100;
    #1;
    checks++;
    if (bus.o_pc_write_en !== 1'b1 || bus.o_pc_next !== 64'h3000_0100)
      $display("FAIL rw_pc: got we=%b next=%h expected 1 30000100", bus.o_pc_write_en, bus.o_pc_next);
    else passed++;
    @(negedge clk);
    bus.i_redirect_valid = 1'b0;
    #1;
    checks++;
    if (bus.o_pc_write_en !== 1'b0 || bus.o_mem_req_valid !== 1'b0 || bus.o_instr_valid !== 1'b0)
      $display("FAIL rw_drain: got we=%b req=%b iv=%b expected 0 0 0", bus.o_pc_write_en, bus.o_mem_req_valid, bus.o_instr_valid);
    else passed++;
    @(negedge clk);
    bus.i_mem_resp_valid = 1'b1;
    bus.i_mem_resp_data  = 32'h0000_0BAD;
    #1;
    checks++;
    if (bus.o_mem_req_valid !== 1'b0 || bus.o_instr_valid !== 1'b0)
      $display("FAIL rw_late: got req=%b iv=%b expected 0 0", bus.o_mem_req_valid, bus.o_instr_valid);
    else passed++;
    @(negedge clk);
    bus.i_mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.o_instr_valid !== 1'b0 || bus.o_mem_req_valid !== 1'b1 || bus.o_mem_addr !== 64'h3000_0100)
      $display("FAIL rw_refetch: got iv=%b req=%b addr=%h expected 0 1 30000100", bus.o_instr_valid, bus.o_mem_req_valid, bus.o_mem_addr);
    else passed++;
    issue_req(addr);
    give_resp(2, 32'h0010_0093, 1'b0, addr);
    consume();
  endtask

  task automatic test_redirect_wait_resp();
    logic [63:0] addr;
    issue_req(addr);
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 64'h3000_0300;
    bus.i_mem_resp_valid = 1'b1;
    bus.i_mem_resp_data  = 32'h0000_0055;
    #1;
    checks++;
    if (bus.o_pc_write_en !== 1'b1 || bus.o_pc_next !== 64'h3000_0300)
      $display("FAIL rwr_pc: got we=%b next=%h expected 1 30000300", bus.o_pc_write_en, bus.o_pc_next);
    else passed++;
    @(negedge clk);
    bus.i_redirect_valid = 1'b0;
    bus.i_mem_resp_valid = 1'b0;
    #1;
    checks++;
    if (bus.o_instr_valid !== 1'b0 || bus.o_mem_req_valid !== 1'b1 || bus.o_mem_addr !== 64'h3000_0300)
      $display("FAIL rwr_req: got iv=%b req=%b addr=%h expected 0 1 30000300", bus.o_instr_valid, bus.o_mem_req_valid, bus.o_mem_addr);
    else passed++;
  endtask

  task automatic test_redirect_hold();
    logic [63:0] addr;
    exp_t dropped;
    issue_req(addr);
    give_resp(1, 32'h0020_0113, 1'b0, addr);
    bus.i_instr_ready    = 1'b1;
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 64'h3000_0200;
    #1;
    checks++;
    if (bus.o_instr_valid !== 1'b0 || bus.o_pc_write_en !== 1'b1 || bus.o_pc_next !== 64'h3000_0200)
      $display("FAIL rh_pc: got iv=%b we=%b next=%h expected 0 1 30000200", bus.o_instr_valid, bus.o_pc_write_en, bus.o_pc_next);
    else passed++;
    dropped = sb.pop_front();
    @(negedge clk);
    bus.i_instr_ready    = 1'b0;
    bus.i_redirect_valid = 1'b0;
    #1;
    checks++;
    if (bus.o_pc_write_en !== 1'b0 || bus.o_instr_valid !== 1'b0 || bus.o_mem_addr !== 64'h3000_0200 || bus.o_mem_addr === dropped.pc + 64'd4)
      $display("FAIL rh_after: got we=%b iv=%b addr=%h expected 0 0 30000200", bus.o_pc_write_en, bus.o_instr_valid, bus.o_mem_addr);
    else passed++;
  endtask

  task automatic test_fault();
    logic [63:0] addr;
    issue_req(addr);
    give_resp(3, 32'hFFFF_FFFF, 1'b1, addr);
    consume();
  endtask

  task automatic test_redirect_req_wrap();
    logic [63:0] addr;
    @(negedge clk);
    bus.i_mem_req_ready  = 1'b1;
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    #1;
    checks++;
    if (bus.o_mem_req_valid !== 1'b0 || bus.o_pc_write_en !== 1'b1 || bus.o_pc_next !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL rq_pc: got req=%b we=%b next=%h expected 0 1 fffffffffffffffc", bus.o_mem_req_valid, bus.o_pc_write_en, bus.o_pc_next);
    else passed++;
    @(negedge clk);
    bus.i_redirect_valid = 1'b0;
    bus.i_mem_req_ready  = 1'b0;
    #1;
    checks++;
    if (bus.o_mem_req_valid !== 1'b1 || bus.o_mem_addr !== 64'hFFFF_FFFF_FFFF_FFFC)
      $display("FAIL rq_stay: got req=%b addr=%h expected 1 fffffffffffffffc", bus.o_mem_req_valid, bus.o_mem_addr);
    else passed++;
    issue_req(addr);
    give_resp(1, 32'h0000_006F, 1'b0, addr);
    consume();
  endtask

  task automatic test_back_to_back();
    logic [63:0] addr;
    for (int i = 0; i < 6; i++) begin
      issue_req(addr);
      give_resp(int'($urandom_range(1, 3)), $urandom, 1'($urandom_range(0, 1)), addr);
      consume();
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [63:0] addr;
    issue_req(addr);
    arstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_mem_req_valid, bus.o_pc_write_en, bus.o_instr_valid, bus.o_instr_fault} !== 4'b0 ||
        bus.o_instr !== 32'h0 || bus.o_instr_pc !== 64'h0 || bus.o_mem_addr !== 64'h0)
      $display("FAIL mid_reset: got req=%b we=%b iv=%b instr=%h ipc=%h addr=%h expected all 0",
               bus.o_mem_req_valid, bus.o_pc_write_en, bus.o_instr_valid, bus.o_instr, bus.o_instr_pc, bus.o_mem_addr);
    else passed++;
    @(negedge clk);
    arstn = 1'b1;
    #1;
    checks++;
    if (bus.o_mem_req_valid !== 1'b1 || bus.o_mem_addr !== RESET_PC || bus.o_instr_valid !== 1'b0)
      $display("FAIL mid_release: got req=%b addr=%h iv=%b expected 1 %h 0", bus.o_mem_req_valid, bus.o_mem_addr, bus.o_instr_valid, RESET_PC);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_wait_resp();
    test_redirect_hold();
    test_fault();
    test_redirect_req_wrap();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
